// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and defaults for the multiply scheduler
package mul_pkg;

    localparam int MUL_XLEN  = 32;
    localparam int MUL_TAG_W = 4;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } sched_state_e;

endpackage

// File: rtl/mul_sched_if.sv
// rtl/mul_sched_if.sv - request/response and multiplier bus of mul_sched
// Signals: req_valid/req_ready/req_op/req_a/req_b/req_tag (2 requesters),
//          resp_valid/resp_ready (per requester), resp_data/resp_tag (shared),
//          mul_a/mul_b/mul_is_signed/mul_stb to the multiplier, mul_o/mul_ack back.
// Modports: slave (scheduler side), master (requesters + multiplier side).
interface mul_sched_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0][1:0]            req_op;
    logic [1:0][XLEN-1:0]       req_a;
    logic [1:0][XLEN-1:0]       req_b;
    logic [1:0][TAG_W-1:0]      req_tag;
    logic [1:0]                 resp_valid;
    logic [1:0]                 resp_ready;
    logic [XLEN-1:0]            resp_data;
    logic [TAG_W-1:0]           resp_tag;
    logic [XLEN-1:0]            mul_a;
    logic [XLEN-1:0]            mul_b;
    logic                       mul_is_signed;
    logic                       mul_stb;
    logic [2*XLEN-1:0]          mul_o;
    logic                       mul_ack;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready, mul_o, mul_ack,
        output req_ready, resp_valid, resp_data, resp_tag, mul_a, mul_b, mul_is_signed, mul_stb
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready, mul_o, mul_ack,
        input  req_ready, resp_valid, resp_data, resp_tag, mul_a, mul_b, mul_is_signed, mul_stb
    );
endinterface

// File: rtl/mul_sched_rr_arb2.sv
// rtl/mul_sched_rr_arb2.sv - two-input round-robin arbiter (module rr_arb2)
// Ports: clk, rst (async, active-high), i_req[1:0] requests,
//        i_take (a grant was consumed this cycle), o_grant[1:0] one-hot grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_grant
);
    // r_ptr names the requester that wins a tie.
    logic r_ptr;

    assign o_grant[0] = i_req[0] & (~i_req[1] | ~r_ptr);
    assign o_grant[1] = i_req[1] & (~i_req[0] |  r_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_take) begin
            // Hand the tie to whoever did not just win.
            r_ptr <= o_grant[0];
        end
    end
endmodule

// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - two-requester scheduler in front of one shared multiplier
// Ports: clk, rst (async, active-high), bus (mul_sched_if.slave) carrying the
//        request/response handshakes and the external multiplier interface.
// Option: MUL_SCHED_REUSE_EN keeps the last full product and answers a request
//         with matching operands/sign mode without starting the multiplier.
module mul_sched
    import mul_pkg::*;
#(
    parameter int XLEN  = MUL_XLEN,
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    mul_sched_if.slave    bus
);
    sched_state_e         r_state;
    mul_op_e              r_op;
    logic [XLEN-1:0]      r_a, r_b;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_idx;
    logic [XLEN-1:0]      r_mul_a, r_mul_b;
    logic                 r_mul_is_signed, r_mul_stb;
    logic [1:0]           r_resp_valid;
    logic [XLEN-1:0]      r_resp_data;
    logic [TAG_W-1:0]     r_resp_tag;

    logic [1:0]           w_grant, w_req_ready;
    logic                 w_take, w_sel, w_signed, w_hit;
    mul_op_e              w_op;
    logic [XLEN-1:0]      w_a, w_b;
    logic [2*XLEN-1:0]    w_cache_prod;

    // MULHSU comes from the unsigned product: a negative rs1 contributes
    // -2^XLEN * b, i.e. b must be subtracted from the high half.
    function automatic logic [XLEN-1:0] f_result(input mul_op_e op,
                                                 input logic [2*XLEN-1:0] prod,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        case (op)
            OP_MUL:    return prod[XLEN-1:0];
            OP_MULHSU: return prod[2*XLEN-1:XLEN] - (a[XLEN-1] ? b : '0);
            default:   return prod[2*XLEN-1:XLEN];
        endcase
    endfunction

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (bus.req_valid),
        .i_take  (w_take),
        .o_grant (w_grant)
    );

    assign w_req_ready = (r_state == S_IDLE && !rst) ? w_grant : 2'b00;
    assign w_take      = |(bus.req_valid & w_req_ready);
    assign w_sel       = w_grant[1];
    assign w_op        = mul_op_e'(bus.req_op[w_sel]);
    assign w_a         = bus.req_a[w_sel];
    assign w_b         = bus.req_b[w_sel];
    assign w_signed    = (w_op == OP_MULH);

`ifdef MUL_SCHED_REUSE_EN
    logic                 r_c_valid, r_c_signed;
    logic [XLEN-1:0]      r_c_a, r_c_b;
    logic [2*XLEN-1:0]    r_c_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_prod   <= '0;
        end else if (r_state == S_WAIT && bus.mul_ack) begin
            r_c_valid  <= 1'b1;
            r_c_signed <= r_mul_is_signed;
            r_c_a      <= r_mul_a;
            r_c_b      <= r_mul_b;
            r_c_prod   <= bus.mul_o;
        end
    end

    // The low half is identical for signed and unsigned products, so MUL
    // can reuse a product taken in either mode.
    assign w_hit        = r_c_valid && r_c_a == w_a && r_c_b == w_b &&
                          (w_op == OP_MUL || r_c_signed == w_signed);
    assign w_cache_prod = r_c_prod;
`else
    assign w_hit        = 1'b0;
    assign w_cache_prod = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_op            <= OP_MUL;
            r_a             <= '0;
            r_b             <= '0;
            r_tag           <= '0;
            r_idx           <= 1'b0;
            r_mul_a         <= '0;
            r_mul_b         <= '0;
            r_mul_is_signed <= 1'b0;
            r_mul_stb       <= 1'b0;
            r_resp_valid    <= 2'b00;
            r_resp_data     <= '0;
            r_resp_tag      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_op  <= w_op;
                        r_a   <= w_a;
                        r_b   <= w_b;
                        r_tag <= bus.req_tag[w_sel];
                        r_idx <= w_sel;
                        if (w_hit) begin
                            r_resp_data  <= f_result(w_op, w_cache_prod, w_a, w_b);
                            r_resp_tag   <= bus.req_tag[w_sel];
                            r_resp_valid <= 2'b01 << w_sel;
                            r_state      <= S_RESP;
                        end else begin
                            r_mul_a         <= w_a;
                            r_mul_b         <= w_b;
                            r_mul_is_signed <= w_signed;
                            r_mul_stb       <= 1'b1;
                            r_state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mul_stb <= 1'b0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mul_ack) begin
                        r_resp_data  <= f_result(r_op, bus.mul_o, r_a, r_b);
                        r_resp_tag   <= r_tag;
                        r_resp_valid <= 2'b01 << r_idx;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready[r_idx]) begin
                        r_resp_valid <= 2'b00;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_tag      = r_resp_tag;
    assign bus.mul_a         = r_mul_a;
    assign bus.mul_b         = r_mul_b;
    assign bus.mul_is_signed = r_mul_is_signed;
    assign bus.mul_stb       = r_mul_stb;
endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - scoreboard testbench for mul_sched
module tb_mul_sched;
    logic clk;
    logic rst;

    mul_sched_if #(.XLEN(32), .TAG_W(4)) bus ();

    mul_sched #(.XLEN(32), .TAG_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   stb_cnt = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rise_cyc = 0;
    logic [31:0] last_data;
    logic [3:0]  last_tag;
    int   last_idx;
    int   mul_lat = 1;
    logic mul_hold = 1'b0;
    logic inj_ack = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0] up;
        up = {32'b0, a} * {32'b0, b};
        case (op)
            2'b00: return up[31:0];
            2'b01: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp[63:32];
            end
            2'b10: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return sp[63:32];
            end
            default: return up[63:32];
        endcase
    endfunction

    // Stand-in multiplier: answers each strobe after mul_lat extra cycles.
    initial begin
        logic busy;
        int   cnt;
        logic signed [63:0] sp;
        logic [63:0] prod;
        busy = 1'b0;
        cnt = 0;
        prod = '0;
        bus.mul_ack = 1'b0;
        bus.mul_o = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mul_ack = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (inj_ack) begin
                bus.mul_ack = 1'b1;
                bus.mul_o = 64'hDEAD_BEEF_CAFE_F00D;
                inj_ack = 1'b0;
            end else if (busy) begin
                if (cnt == 0) begin
                    bus.mul_ack = 1'b1;
                    bus.mul_o = prod;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (bus.mul_stb && !mul_hold) begin
                if (bus.mul_is_signed) begin
                    sp = $signed({{32{bus.mul_a[31]}}, bus.mul_a}) * $signed({{32{bus.mul_b[31]}}, bus.mul_b});
                    prod = sp;
                end else begin
                    prod = {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
                end
                cnt = mul_lat;
                busy = 1'b1;
            end
        end
    end

    // Monitor: push on accept, pop and compare on response handshake.
    initial begin
        logic ack_prev, stb_prev, resp_prev;
        exp_t e;
        ack_prev = 1'b0;
        stb_prev = 1'b0;
        resp_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                ack_prev = 1'b0;
                stb_prev = 1'b0;
                resp_prev = 1'b0;
            end else begin
                if (ack_prev && exp_q.size() > 0)
                    chk("resp_after_ack", {63'b0, |bus.resp_valid}, 64'd1);
                if (|bus.resp_valid && !resp_prev)
                    rise_cyc = cyc;
                if (bus.mul_stb) begin
                    stb_cnt++;
                    chk("stb_single", {63'b0, stb_prev}, 64'd0);
                    if (exp_q.size() > 0) begin
                        chk("stb_signed", {63'b0, bus.mul_is_signed}, {63'b0, exp_q[0].op == 2'b01});
                        chk("stb_a", {32'b0, bus.mul_a}, {32'b0, exp_q[0].a});
                        chk("stb_b", {32'b0, bus.mul_b}, {32'b0, exp_q[0].b});
                    end
                end
                if (|(bus.resp_valid & bus.resp_ready)) begin
                    chk("resp_outstanding", exp_q.size(), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("resp_owner", {62'b0, bus.resp_valid}, 64'd1 << e.idx);
                        chk("resp_data", {32'b0, bus.resp_data}, {32'b0, e.data});
                        chk("resp_tag", {60'b0, bus.resp_tag}, {60'b0, e.tag});
                    end
                    last_data = bus.resp_data;
                    last_tag = bus.resp_tag;
                    last_idx = bus.resp_valid[1] ? 1 : 0;
                end
                for (int k = 0; k < 2; k++) begin
                    if (bus.req_valid[k] && bus.req_ready[k]) begin
                        e.idx = k;
                        e.op = bus.req_op[k];
                        e.a = bus.req_a[k];
                        e.b = bus.req_b[k];
                        e.tag = bus.req_tag[k];
                        e.data = ref_mul(bus.req_op[k], bus.req_a[k], bus.req_b[k]);
                        exp_q.push_back(e);
                        grant_log.push_back(k);
                        acc_cyc = cyc;
                    end
                end
                ack_prev = bus.mul_ack;
                stb_prev = bus.mul_stb;
                resp_prev = |bus.resp_valid;
            end
        end
    end

    task automatic set_req(input int idx, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
        bus.req_op[idx] = op;
        bus.req_a[idx] = a;
        bus.req_b[idx] = b;
        bus.req_tag[idx] = tag;
    endtask

    task automatic send(input int idx, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
        logic ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        set_req(idx, op, a, b, tag);
        bus.req_valid[idx] = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid[idx] = 1'b0;
        if (!ok) chk("send_accept", {63'b0, ok}, 64'd1);
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("drain", exp_q.size(), 64'd0);
    endtask

    task automatic run_both(input int n, output int base);
        logic ok;
        ok = 1'b0;
        base = grant_log.size();
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 800 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (grant_log.size() >= base + n) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        if (!ok) chk("both_grants", grant_log.size(), base + n);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, {62'b0, bus.req_ready}, 64'd0);
        chk({pfx, "_resp_valid"}, {62'b0, bus.resp_valid}, 64'd0);
        chk({pfx, "_mul_stb"}, {63'b0, bus.mul_stb}, 64'd0);
        chk({pfx, "_mul_a"}, {32'b0, bus.mul_a}, 64'd0);
        chk({pfx, "_mul_b"}, {32'b0, bus.mul_b}, 64'd0);
        chk({pfx, "_mul_signed"}, {63'b0, bus.mul_is_signed}, 64'd0);
        chk({pfx, "_resp_data"}, {32'b0, bus.resp_data}, 64'd0);
        chk({pfx, "_resp_tag"}, {60'b0, bus.resp_tag}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        int acc;
        int s1;
        logic ok;
        logic [31:0] held_data;
        logic [3:0]  held_tag;
        logic [31:0] ra, rb;

        rst = 1'b1;
        bus.resp_ready = 2'b11;
        bus.req_valid = 2'b11;
        set_req(0, 2'b00, 32'h1, 32'h2, 4'h1);
        set_req(1, 2'b00, 32'h3, 32'h4, 4'h2);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        send(0, 2'b01, 32'hFFFF_FFFD, 32'd5, 4'h3);
        drain();
        chk("mulh_data", {32'b0, last_data}, 64'hFFFF_FFFF);
        chk("mulh_owner", last_idx, 64'd0);

        send(1, 2'b00, 32'hFFFF_FFFD, 32'd5, 4'h9);
        drain();
        chk("mul_data", {32'b0, last_data}, 64'hFFFF_FFF1);
        chk("mul_tag", {60'b0, last_tag}, 64'h9);
        chk("mul_owner", last_idx, 64'd1);

        send(1, 2'b10, 32'hFFFF_FFFF, 32'd2, 4'h5);
        drain();
        chk("mulhsu_data", {32'b0, last_data}, 64'hFFFF_FFFF);

        mul_lat = 3;
        send(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h6);
        drain();
        chk("mulhu_data", {32'b0, last_data}, 64'hFFFF_FFFE);

        // Last grant went to requester 1, so continuous contention starts at 0.
        set_req(0, 2'b00, 32'd7, 32'd9, 4'h1);
        set_req(1, 2'b11, 32'h8000_0000, 32'h3, 4'h2);
        mul_lat = 0;
        run_both(4, base);
        drain();
        for (int i = 0; i < 4; i++)
            if (base + i < grant_log.size())
                chk("alt_grant", grant_log[base + i], i % 2);

        // Held response with the other requester waiting and its ready high.
        send(0, 2'b00, 32'h1234, 32'h10, 4'hA);
        bus.resp_ready = 2'b10;
        set_req(1, 2'b01, 32'h5, 32'hFFFF_FFFF, 4'hB);
        bus.req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.resp_valid[0]) ok = 1'b1;
        end
        chk("stall_resp_seen", {63'b0, ok}, 64'd1);
        held_data = bus.resp_data;
        held_tag = bus.resp_tag;
        bad = 0;
        acc = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b01 || bus.resp_data != held_data || bus.resp_tag != held_tag) bad++;
            if (bus.req_ready != 2'b00) acc++;
        end
        chk("stall_hold", bad, 64'd0);
        chk("stall_no_accept", acc, 64'd0);
        chk("stall_data", {32'b0, held_data}, 64'h12340);
        chk("stall_tag", {60'b0, held_tag}, 64'hA);
        @(posedge clk);
        #1;
        bus.resp_ready = 2'b11;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready[1]) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        chk("stall_release_accept", {63'b0, ok}, 64'd1);
        drain();

        // Reset while waiting on the multiplier; requester 0 owned the op,
        // so a pointer that survived reset would favour requester 1.
        mul_hold = 1'b1;
        send(0, 2'b11, 32'hAAAA, 32'h5555, 4'h7);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req_valid = 2'b11;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        mul_hold = 1'b0;
        @(negedge clk);
        inj_ack = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00 || bus.mul_stb) bad++;
        end
        chk("late_ack_ignored", bad, 64'd0);
        set_req(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 4'hC);
        set_req(1, 2'b10, 32'h8000_0001, 32'hFFFF_FFFF, 4'hD);
        run_both(2, base);
        drain();
        if (base + 1 < grant_log.size()) begin
            chk("ptr_reset_first", grant_log[base], 64'd0);
            chk("ptr_reset_second", grant_log[base + 1], 64'd1);
        end

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
            mul_lat = $urandom_range(0, 4);
            send($urandom_range(0, 1), 2'($urandom_range(0, 3)), ra, rb, 4'($urandom_range(0, 15)));
            drain();
        end

        // Same operands twice: MULH then MUL.
        mul_lat = 0;
        send(0, 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 4'h1);
        drain();
        s1 = stb_cnt;
        send(1, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 4'h2);
        drain();
`ifdef MUL_SCHED_REUSE_EN
        chk("reuse_no_stb", stb_cnt, s1);
        chk("reuse_latency", rise_cyc - acc_cyc, 64'd1);
`else
        chk("noreuse_stb", stb_cnt, s1 + 1);
        chk("min_latency", rise_cyc - acc_cyc, 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
